// File: rtl/uart_frame_rx_pkg.sv
// Shared types and helpers for the framed-packet receiver.
package uart_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_HOLD = 3'd5
    } frame_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Frame is good when the running sum plus the received checksum wraps to zero.
    function automatic logic csum_good(input logic [7:0] sum, input logic [7:0] csum);
        logic [7:0] total;
        total = sum + csum;
        return (total == 8'h00);
    endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte-stream input, packet read-out and error pulses of the frame receiver.
interface uart_frame_rx_if #(
    parameter int MAX_LEN = 64
);
    localparam int AW = $clog2(MAX_LEN);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          pkt_valid;
    logic [7:0]    pkt_cmd;
    logic [7:0]    pkt_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pkt_ack;
    logic          err_crc;
    logic          err_len;
    logic          err_timeout;

    modport master (
        output rx_data, rx_valid, rd_addr, pkt_ack,
        input  rx_ready, pkt_valid, pkt_cmd, pkt_len, rd_data,
               err_crc, err_len, err_timeout
    );

    modport slave (
        input  rx_data, rx_valid, rd_addr, pkt_ack,
        output rx_ready, pkt_valid, pkt_cmd, pkt_len, rd_data,
               err_crc, err_len, err_timeout
    );

endinterface

// File: rtl/uart_frame_rx_buf.sv
// Payload buffer: synchronous write, registered read (single block RAM).
module uart_frame_rx_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= 8'h00;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_frame_rx.sv
// Framed-packet receiver: SYNC hunt, length/checksum check, payload buffering,
// inter-byte timeout, and hold-until-ack hand-off to the command logic.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int         MAX_LEN = 64,
    parameter int         TIMEOUT = 12000,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    uart_frame_rx_if.slave  bus
);

    localparam int         AW         = $clog2(MAX_LEN);
    localparam int         TW         = $clog2(TIMEOUT + 1);
    localparam logic [8:0] MAX_LEN_9  = 9'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    frame_state_t  r_state;
    frame_state_t  w_state_next;
    logic [7:0]    r_cmd;
    logic [7:0]    r_len;
    logic [7:0]    r_sum;
    logic [AW-1:0] r_idx;
    logic [TW-1:0] r_tmo;
    logic          r_rx_ready;
    logic          r_pkt_valid;
    logic          r_err_crc;
    logic          r_err_len;
    logic          r_err_tmo;

    logic w_xfer;
    logic w_timed;
    logic w_tmo_hit;
    logic w_last;
    logic w_len_bad;
    logic w_csum_ok;
    logic w_we;
    logic w_set_crc;
    logic w_set_len;
    logic w_set_tmo;

    assign w_xfer    = bus.rx_valid & r_rx_ready;
    assign w_timed   = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                       (r_state == ST_DATA) || (r_state == ST_CSUM);
    // An accepted byte in the same cycle as expiry takes precedence.
    assign w_tmo_hit = w_timed & ~w_xfer & (r_tmo == TMO_LAST);
    assign w_last    = (8'(r_idx) == (r_len - 8'd1));
    assign w_len_bad = ({1'b0, bus.rx_data} > MAX_LEN_9);
    assign w_csum_ok = csum_good(r_sum, bus.rx_data);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && (bus.rx_data == SYNC)) w_state_next = ST_CMD;
                else                                 w_state_next = ST_IDLE;
            end
            ST_CMD: begin
                if (w_xfer)         w_state_next = ST_LEN;
                else if (w_tmo_hit) w_state_next = ST_IDLE;
                else                w_state_next = ST_CMD;
            end
            ST_LEN: begin
                if (w_xfer) begin
                    if (w_len_bad)                  w_state_next = ST_IDLE;
                    else if (bus.rx_data == 8'h00)  w_state_next = ST_CSUM;
                    else                            w_state_next = ST_DATA;
                end else if (w_tmo_hit) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_LEN;
                end
            end
            ST_DATA: begin
                if (w_xfer && w_last) w_state_next = ST_CSUM;
                else if (w_xfer)      w_state_next = ST_DATA;
                else if (w_tmo_hit)   w_state_next = ST_IDLE;
                else                  w_state_next = ST_DATA;
            end
            ST_CSUM: begin
                if (w_xfer && w_csum_ok) w_state_next = ST_HOLD;
                else if (w_xfer)         w_state_next = ST_IDLE;
                else if (w_tmo_hit)      w_state_next = ST_IDLE;
                else                     w_state_next = ST_CSUM;
            end
            ST_HOLD: begin
                if (bus.pkt_ack) w_state_next = ST_IDLE;
                else             w_state_next = ST_HOLD;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Per-state strobes: buffer write and error pulse requests.
    always_comb begin
        w_we      = 1'b0;
        w_set_crc = 1'b0;
        w_set_len = 1'b0;
        w_set_tmo = w_tmo_hit;
        case (r_state)
            ST_LEN:  w_set_len = w_xfer & w_len_bad;
            ST_DATA: w_we      = w_xfer;
            ST_CSUM: w_set_crc = w_xfer & ~w_csum_ok;
            default: w_we      = 1'b0;
        endcase
    end

    // Registered outputs, timer and frame datapath.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_ready  <= 1'b1;
            r_pkt_valid <= 1'b0;
            r_err_crc   <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_tmo       <= '0;
            r_cmd       <= 8'h00;
            r_len       <= 8'h00;
            r_sum       <= 8'h00;
            r_idx       <= '0;
        end else begin
            r_rx_ready  <= (w_state_next != ST_HOLD);
            r_pkt_valid <= (w_state_next == ST_HOLD);
            r_err_crc   <= w_set_crc;
            r_err_len   <= w_set_len;
            r_err_tmo   <= w_set_tmo;
            if (w_xfer || (w_state_next != r_state)) begin
                r_tmo <= '0;
            end else if (w_timed) begin
                r_tmo <= r_tmo + TW'(1);
            end else begin
                r_tmo <= '0;
            end
            if (w_xfer) begin
                case (r_state)
                    ST_CMD: begin
                        r_cmd <= bus.rx_data;
                        r_sum <= bus.rx_data;
                    end
                    ST_LEN: begin
                        r_len <= bus.rx_data;
                        r_sum <= r_sum + bus.rx_data;
                        r_idx <= '0;
                    end
                    ST_DATA: begin
                        r_sum <= r_sum + bus.rx_data;
                        r_idx <= r_idx + AW'(1);
                    end
                    default: r_sum <= r_sum;
                endcase
            end
        end
    end

    uart_frame_rx_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (bus.rx_data),
        .i_raddr (bus.rd_addr),
        .o_rdata (bus.rd_data)
    );

    assign bus.rx_ready    = r_rx_ready;
    assign bus.pkt_valid   = r_pkt_valid;
    assign bus.pkt_cmd     = r_cmd;
    assign bus.pkt_len     = r_len;
    assign bus.err_crc     = r_err_crc;
    assign bus.err_len     = r_err_len;
    assign bus.err_timeout = r_err_tmo;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with a short timeout; bytes driven straight onto the handshake.
module tb_uart_frame_rx;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_crc    = 0;
    int   n_len    = 0;
    int   n_tmo    = 0;
    int   n_multi  = 0;
    logic [7:0] frame [$];

    uart_frame_rx_if #(.MAX_LEN(64)) bus ();

    uart_frame_rx #(
        .MAX_LEN (64),
        .TIMEOUT (200),
        .SYNC    (8'hA5)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.err_crc)     n_crc++;
        if (bus.err_len)     n_len++;
        if (bus.err_timeout) n_tmo++;
        if (32'(bus.err_crc) + 32'(bus.err_len) + 32'(bus.err_timeout) > 32'd1) n_multi++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q [$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic read_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus.rd_addr = a;
        @(negedge clk);
        check_eq(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic check_pkt(input string tag, input logic [7:0] cmd, input logic [7:0] len);
        check_eq({tag, "_valid"}, 32'(bus.pkt_valid), 32'd1);
        check_eq({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
        check_eq({tag, "_cmd"}, 32'(bus.pkt_cmd), 32'(cmd));
        check_eq({tag, "_len"}, 32'(bus.pkt_len), 32'(len));
    endtask

    task automatic ack_chk(input string tag);
        @(negedge clk);
        bus.pkt_ack = 1'b1;
        @(negedge clk);
        bus.pkt_ack = 1'b0;
        check_eq({tag, "_rel_valid"}, 32'(bus.pkt_valid), 32'd0);
        check_eq({tag, "_rel_ready"}, 32'(bus.rx_ready), 32'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rd_addr  = 6'd0;
        bus.pkt_ack  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(bus.rx_ready), 32'd1);
        check_eq("rst_valid", 32'(bus.pkt_valid), 32'd0);
        check_eq("rst_cmd", 32'(bus.pkt_cmd), 32'd0);
        check_eq("rst_len", 32'(bus.pkt_len), 32'd0);
        check_eq("rst_rdata", 32'(bus.rd_data), 32'd0);
        check_eq("rst_errs", 32'({bus.err_crc, bus.err_len, bus.err_timeout}), 32'd0);
        resetn = 1'b1;

        // Good frame, then ack while nothing else is pending.
        frame = {8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h96};
        send_q(frame);
        check_pkt("t1", 8'h01, 8'h03);
        read_chk("t1_rd0", 6'd0, 8'h11);
        read_chk("t1_rd1", 6'd1, 8'h22);
        read_chk("t1_rd2", 6'd2, 8'h33);
        repeat (5) @(negedge clk);
        check_eq("t1_hold_ready", 32'(bus.rx_ready), 32'd0);
        check_eq("t1_hold_valid", 32'(bus.pkt_valid), 32'd1);
        ack_chk("t1");

        // Bad checksum, then the same frame corrected.
        frame = {8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_q(frame);
        check_eq("t2_crc_pulse", 32'(bus.err_crc), 32'd1);
        @(negedge clk);
        check_eq("t2_crc_once", 32'(bus.err_crc), 32'd0);
        check_eq("t2_crc_cnt", 32'(n_crc), 32'd1);
        check_eq("t2_no_valid", 32'(bus.pkt_valid), 32'd0);
        frame = {8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h96};
        send_q(frame);
        check_pkt("t2b", 8'h01, 8'h03);
        read_chk("t2b_rd1", 6'd1, 8'h22);
        ack_chk("t2b");

        // Leading junk dropped, zero-length payload.
        frame = {8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'hF9};
        send_q(frame);
        check_pkt("t3", 8'h07, 8'h00);
        ack_chk("t3");

        // Oversize length, then a recovery frame preceded by junk.
        frame = {8'hA5, 8'h01, 8'h41};
        send_q(frame);
        check_eq("t4_len_pulse", 32'(bus.err_len), 32'd1);
        @(negedge clk);
        check_eq("t4_len_cnt", 32'(n_len), 32'd1);
        check_eq("t4_ready", 32'(bus.rx_ready), 32'd1);
        frame = {8'h11, 8'hA5, 8'h02, 8'h01, 8'h55, 8'hA8};
        send_q(frame);
        check_pkt("t4b", 8'h02, 8'h01);
        read_chk("t4b_rd0", 6'd0, 8'h55);
        ack_chk("t4b");

        // Inter-byte timeout fires exactly TIMEOUT cycles after the last byte.
        frame = {8'hA5, 8'h01};
        send_q(frame);
        repeat (199) @(negedge clk);
        check_eq("t5_tmo_early", 32'(bus.err_timeout), 32'd0);
        @(negedge clk);
        check_eq("t5_tmo_pulse", 32'(bus.err_timeout), 32'd1);
        @(negedge clk);
        check_eq("t5_tmo_once", 32'(bus.err_timeout), 32'd0);
        check_eq("t5_tmo_cnt", 32'(n_tmo), 32'd1);
        frame = {8'hA5, 8'h07, 8'h00, 8'hF9};
        send_q(frame);
        check_pkt("t5b", 8'h07, 8'h00);
        ack_chk("t5b");

        // SYNC value inside the payload is ordinary data.
        frame = {8'hA5, 8'h03, 8'h02, 8'hA5, 8'hA5, 8'hB1};
        send_q(frame);
        check_pkt("sd", 8'h03, 8'h02);
        read_chk("sd_rd1", 6'd1, 8'hA5);
        ack_chk("sd");

        // Full-length payload at the buffer limit.
        frame = {8'hA5, 8'h05, 8'h40};
        for (int i = 0; i < 64; i++) frame.push_back(8'(i));
        frame.push_back(8'hDB);
        send_q(frame);
        check_pkt("max", 8'h05, 8'h40);
        read_chk("max_rd0", 6'd0, 8'h00);
        read_chk("max_rd32", 6'd32, 8'h20);
        read_chk("max_rd63", 6'd63, 8'h3F);
        ack_chk("max");

        // Reset in the middle of a payload.
        frame = {8'hA5, 8'h01, 8'h03, 8'h11};
        send_q(frame);
        reset_pulse();
        check_eq("t6a_valid", 32'(bus.pkt_valid), 32'd0);
        check_eq("t6a_ready", 32'(bus.rx_ready), 32'd1);
        frame = {8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h96};
        send_q(frame);
        check_pkt("t6a_next", 8'h01, 8'h03);

        // Reset while a packet is held.
        reset_pulse();
        check_eq("t6b_valid", 32'(bus.pkt_valid), 32'd0);
        check_eq("t6b_ready", 32'(bus.rx_ready), 32'd1);
        check_eq("t6b_cmd", 32'(bus.pkt_cmd), 32'd0);
        frame = {8'hA5, 8'h07, 8'h00, 8'hF9};
        send_q(frame);
        check_pkt("t6b_next", 8'h07, 8'h00);
        ack_chk("t6b_next");

        repeat (2) @(negedge clk);
        check_eq("tot_crc", 32'(n_crc), 32'd1);
        check_eq("tot_len", 32'(n_len), 32'd1);
        check_eq("tot_tmo", 32'(n_tmo), 32'd1);
        check_eq("err_exclusive", 32'(n_multi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
